// File: rtl/zoom_sequencer.sv
// Region-select interrupt sequencer: zooms into a selected square, restores a prior view, or ignores a click.
// All view arithmetic shares one sequential shift-add multiplier; the view history is a wrapping stack.
module zoom_sequencer #(
  parameter int COORD_W = 32,
  parameter int STACK_DEPTH = 8,
  parameter logic signed [COORD_W-1:0] DEF_X0 = 32'shE0000000,
  parameter logic signed [COORD_W-1:0] DEF_Y0 = 32'shE8000000,
  parameter logic signed [COORD_W-1:0] DEF_STEP = 32'd1048576,
  parameter int FIG_SIZE = 768,
  parameter int RECIP = 87381,
  parameter int RECIP_SHIFT = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               interrupt,
  output logic               interrupt_ack,
  input  logic               mouse_zoom,
  input  logic               mouse_restore,
  input  logic               mouse_click,
  input  logic [10:0]        left_pos_x,
  input  logic [10:0]        bot_pos_y,
  input  logic [9:0]         sel_length,
  input  logic               engine_idle,
  output logic               render_start,
  output logic [COORD_W-1:0] view_x0,
  output logic [COORD_W-1:0] view_y0,
  output logic [COORD_W-1:0] view_step,
  output logic [3:0]         stack_cnt,
  output logic               busy
);

  localparam int PTR_W  = $clog2(STACK_DEPTH);
  localparam int ACC_W  = 64;
  localparam int MPLR_W = 17;
  localparam int CNT_W  = 5;
  localparam logic [MPLR_W-1:0] RECIP_V = MPLR_W'(RECIP);
  localparam logic [10:0]       TOP_ROW = 11'(FIG_SIZE - 1);
  localparam logic [3:0]        FULL    = 4'(STACK_DEPTH);

  typedef enum logic [3:0] {
    IDLE, DECODE, PUSH, MUL_X, MUL_Y, MUL_S1, MUL_S2,
    COMMIT, POP, WAIT_ENG, START, ACK
  } state_t;

  state_t state, state_nxt;

  logic zl, rl, cl;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COORD_W-1:0] stk_x [STACK_DEPTH];
  logic [COORD_W-1:0] stk_y [STACK_DEPTH];
  logic [COORD_W-1:0] stk_s [STACK_DEPTH];

  logic [ACC_W-1:0]   acc, acc_nxt, mcand, step_ext;
  logic [MPLR_W-1:0]  mplr;
  logic [CNT_W-1:0]   mul_cnt;
  logic               mul_last;
  logic [10:0]        cap_y, cap_w;
  logic [COORD_W-1:0] px, py, s_res;

  assign rd_ptr   = wr_ptr - PTR_W'(1);
  assign step_ext = {{(ACC_W-COORD_W){view_step[COORD_W-1]}}, view_step};
  assign acc_nxt  = acc + (mplr[0] ? mcand : '0);
  // The RECIP stage runs one cycle per RECIP bit; the other stages one per 11-bit operand bit.
  assign mul_last = (state == MUL_S2) ? (mul_cnt == CNT_W'(MPLR_W - 1))
                                      : (mul_cnt == CNT_W'(10));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    render_start  = 1'b0;
    interrupt_ack = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:     if (interrupt) state_nxt = DECODE;
      DECODE: begin
        if (rl)                             state_nxt = POP;
        else if (zl && sel_length != 10'd0) state_nxt = PUSH;
        else                                state_nxt = WAIT_ENG;
      end
      PUSH:     state_nxt = MUL_X;
      MUL_X:    if (mul_last) state_nxt = MUL_Y;
      MUL_Y:    if (mul_last) state_nxt = MUL_S1;
      MUL_S1:   if (mul_last) state_nxt = MUL_S2;
      MUL_S2:   if (mul_last) state_nxt = COMMIT;
      COMMIT:   state_nxt = WAIT_ENG;
      POP:      state_nxt = WAIT_ENG;
      WAIT_ENG: if (engine_idle) state_nxt = START;
      START: begin
        render_start = 1'b1;
        state_nxt    = ACK;
      end
      ACK: begin
        interrupt_ack = 1'b1;
        state_nxt     = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == PUSH) begin
      stk_x[wr_ptr] <= view_x0;
      stk_y[wr_ptr] <= view_y0;
      stk_s[wr_ptr] <= view_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      view_x0   <= DEF_X0;
      view_y0   <= DEF_Y0;
      view_step <= DEF_STEP;
      stack_cnt <= '0;
      wr_ptr    <= '0;
      zl        <= 1'b0;
      rl        <= 1'b0;
      cl        <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      mul_cnt   <= '0;
      cap_y     <= '0;
      cap_w     <= '0;
      px        <= '0;
      py        <= '0;
      s_res     <= '0;
    end else begin
      if (state == ACK) begin
        zl <= 1'b0;
        rl <= 1'b0;
        cl <= 1'b0;
      end else begin
        if (mouse_zoom)    zl <= 1'b1;
        if (mouse_restore) rl <= 1'b1;
        if (mouse_click)   cl <= 1'b1;
      end

      case (state)
        PUSH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (stack_cnt != FULL) stack_cnt <= stack_cnt + 4'd1;
          cap_y   <= (bot_pos_y > TOP_ROW) ? 11'd0 : TOP_ROW - bot_pos_y;
          cap_w   <= {sel_length, 1'b1};
          mcand   <= step_ext;
          mplr    <= {{(MPLR_W-11){1'b0}}, left_pos_x};
          acc     <= '0;
          mul_cnt <= '0;
        end
        MUL_X, MUL_Y, MUL_S1, MUL_S2: begin
          if (!mul_last) begin
            acc     <= acc_nxt;
            mcand   <= mcand << 1;
            mplr    <= mplr >> 1;
            mul_cnt <= mul_cnt + CNT_W'(1);
          end else begin
            // Each stage's final cycle stores its result and loads the next operands.
            acc     <= '0;
            mul_cnt <= '0;
            case (state)
              MUL_X: begin
                px    <= acc_nxt[COORD_W-1:0];
                mcand <= step_ext;
                mplr  <= {{(MPLR_W-11){1'b0}}, cap_y};
              end
              MUL_Y: begin
                py    <= acc_nxt[COORD_W-1:0];
                mcand <= step_ext;
                mplr  <= {{(MPLR_W-11){1'b0}}, cap_w};
              end
              MUL_S1: begin
                mcand <= acc_nxt;
                mplr  <= RECIP_V;
              end
              default: s_res <= acc_nxt[RECIP_SHIFT +: COORD_W];
            endcase
          end
        end
        COMMIT: begin
          view_x0   <= view_x0 + px;
          view_y0   <= view_y0 + py;
          view_step <= (s_res == '0) ? COORD_W'(1) : s_res;
        end
        POP: begin
          if (stack_cnt != 4'd0) begin
            view_x0   <= stk_x[rd_ptr];
            view_y0   <= stk_y[rd_ptr];
            view_step <= stk_s[rd_ptr];
            wr_ptr    <= rd_ptr;
            stack_cnt <= stack_cnt - 4'd1;
          end else begin
            view_x0   <= DEF_X0;
            view_y0   <= DEF_Y0;
            view_step <= DEF_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_sequencer.sv
// Bench for zoom_sequencer: reference view model feeds a scoreboard of expected views per interrupt.
module tb_zoom_sequencer;

  localparam int DEF_X0   = 32'shE0000000;
  localparam int DEF_Y0   = 32'shE8000000;
  localparam int DEF_STEP = 1048576;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        interrupt = 1'b0;
  logic        interrupt_ack;
  logic        mouse_zoom = 1'b0;
  logic        mouse_restore = 1'b0;
  logic        mouse_click = 1'b0;
  logic [10:0] left_pos_x = '0;
  logic [10:0] bot_pos_y = '0;
  logic [9:0]  sel_length = '0;
  logic        engine_idle = 1'b1;
  logic        render_start;
  logic [31:0] view_x0, view_y0, view_step;
  logic [3:0]  stack_cnt;
  logic        busy;

  zoom_sequencer dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .mouse_zoom(mouse_zoom), .mouse_restore(mouse_restore), .mouse_click(mouse_click),
    .left_pos_x(left_pos_x), .bot_pos_y(bot_pos_y), .sel_length(sel_length),
    .engine_idle(engine_idle), .render_start(render_start),
    .view_x0(view_x0), .view_y0(view_y0), .view_step(view_step),
    .stack_cnt(stack_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {int x0; int y0; int step;} view_t;
  typedef struct {view_t v; int cnt; int lat;} exp_t;

  view_t mv;
  view_t mstk[$];
  exp_t  sb[$];

  function automatic int scale(input int step, input int w);
    longint p;
    int s;
    p = (longint'(step) * longint'(w)) * longint'(87381);
    s = int'(p >>> 26);
    if (s == 0) s = 1;
    return s;
  endfunction

  // kind: 0 zoom, 1 restore, 2 click
  task automatic expect_op(input int kind, input int lx, input int by, input int sl);
    exp_t e;
    int yt, lat;
    if (kind == 1) begin
      if (mstk.size() > 0) mv = mstk.pop_back();
      else mv = '{DEF_X0, DEF_Y0, DEF_STEP};
      lat = 3;
    end else if (kind == 0 && sl != 0) begin
      mstk.push_back(mv);
      if (mstk.size() > 8) mstk.delete(0);
      yt = (by > 767) ? 0 : 767 - by;
      mv.x0 = mv.x0 + int'(longint'(mv.step) * longint'(lx));
      mv.y0 = mv.y0 + int'(longint'(mv.step) * longint'(yt));
      mv.step = scale(mv.step, 2 * sl + 1);
      lat = 54;
    end else begin
      lat = 2;
    end
    e.v = mv;
    e.cnt = mstk.size();
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_done(output int lat_s, output int lat_a, output int starts);
    int t_busy, t_start;
    bit ok;
    t_busy = -1; t_start = -1; starts = 0; ok = 1'b0; lat_s = -1; lat_a = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && t_busy < 0) t_busy = cyc;
      if (render_start === 1'b1) begin starts++; t_start = cyc; end
      if (interrupt_ack === 1'b1) begin
        ok = 1'b1;
        lat_s = t_start - t_busy;
        lat_a = cyc - t_busy;
        break;
      end
    end
    interrupt = 1'b0;
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL ack_timeout: no interrupt_ack within 400 cycles");
    end
  endtask

  task automatic run_op(input int kind, input int lx, input int by, input int sl,
                        output int lat_s, output int lat_a, output int starts);
    @(negedge clk);
    left_pos_x = 11'(lx); bot_pos_y = 11'(by); sel_length = 10'(sl);
    mouse_zoom = (kind == 0); mouse_restore = (kind == 1); mouse_click = (kind == 2);
    @(negedge clk);
    mouse_zoom = 1'b0; mouse_restore = 1'b0; mouse_click = 1'b0;
    interrupt = 1'b1;
    wait_done(lat_s, lat_a, starts);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mv = '{DEF_X0, DEF_Y0, DEF_STEP};
    mstk.delete();
    @(negedge clk);
    compared++;
    if ({view_x0, view_y0, view_step, stack_cnt} !== {DEF_X0, DEF_Y0, DEF_STEP, 4'd0}) begin
      mismatched++;
      $display("FAIL reset_view: got %h %h %h cnt %0d, want %h %h %h cnt 0",
               view_x0, view_y0, view_step, stack_cnt, DEF_X0, DEF_Y0, DEF_STEP);
    end
    compared++;
    if ({busy, render_start, interrupt_ack} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_ctrl: busy/start/ack got %b%b%b, want 000", busy, render_start, interrupt_ack);
    end
  endtask

  task automatic test_first_zoom;
    exp_t e; int ls, la, st;
    expect_op(0, 0, 767, 383);
    run_op(0, 0, 767, 383, ls, la, st);
    e = sb.pop_front();
    compared++;
    if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)}) begin
      mismatched++;
      $display("FAIL first_zoom_view: got %h %h %h cnt %0d, want %h %h %h cnt %0d",
               view_x0, view_y0, view_step, stack_cnt, e.v.x0, e.v.y0, e.v.step, e.cnt);
    end
    compared++;
    if (ls !== e.lat || la !== e.lat + 1 || st !== 1) begin
      mismatched++;
      $display("FAIL first_zoom_latency: start %0d ack %0d starts %0d, want %0d %0d 1", ls, la, st, e.lat, e.lat + 1);
    end
  endtask

  task automatic test_quarter_zoom;
    exp_t e; int ls, la, st;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin expect_op(1, 0, 0, 0); run_op(1, 0, 0, 0, ls, la, st); end
      else begin expect_op(0, 384, 383, 95); run_op(0, 384, 383, 95, ls, la, st); end
      e = sb.pop_front();
      compared++;
      if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)} || ls !== e.lat) begin
        mismatched++;
        $display("FAIL quarter_zoom_%0d: got %h %h %h cnt %0d lat %0d, want %h %h %h cnt %0d lat %0d", k,
                 view_x0, view_y0, view_step, stack_cnt, ls, e.v.x0, e.v.y0, e.v.step, e.cnt, e.lat);
      end
    end
  endtask

  task automatic test_restore;
    exp_t e; int ls, la, st;
    for (int k = 0; k < 2; k++) begin
      expect_op(1, 0, 0, 0);
      run_op(1, 0, 0, 0, ls, la, st);
      e = sb.pop_front();
      compared++;
      if ({view_x0, view_y0, view_step, stack_cnt} !== {DEF_X0, DEF_Y0, DEF_STEP, 4'd0} || ls !== e.lat || st !== 1) begin
        mismatched++;
        $display("FAIL restore_%0d: got %h %h %h cnt %0d lat %0d starts %0d, want defaults cnt 0 lat %0d starts 1",
                 k, view_x0, view_y0, view_step, stack_cnt, ls, st, e.lat);
      end
    end
  endtask

  task automatic test_overflow;
    exp_t e; view_t v1; int ls, la, st, lx, by, sl;
    for (int k = 0; k < 9; k++) begin
      lx = $urandom_range(0, 1500);
      by = (k == 4) ? 900 : $urandom_range(0, 767);
      sl = $urandom_range(1, 383);
      expect_op(0, lx, by, sl);
      if (k == 0) v1 = mv;
      run_op(0, lx, by, sl, ls, la, st);
      e = sb.pop_front();
      compared++;
      if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)}) begin
        mismatched++;
        $display("FAIL overflow_zoom_%0d: got %h %h %h cnt %0d, want %h %h %h cnt %0d", k,
                 view_x0, view_y0, view_step, stack_cnt, e.v.x0, e.v.y0, e.v.step, e.cnt);
      end
    end
    for (int k = 0; k < 9; k++) begin
      expect_op(1, 0, 0, 0);
      run_op(1, 0, 0, 0, ls, la, st);
      e = sb.pop_front();
      compared++;
      if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)}) begin
        mismatched++;
        $display("FAIL overflow_restore_%0d: got %h %h %h cnt %0d, want %h %h %h cnt %0d", k,
                 view_x0, view_y0, view_step, stack_cnt, e.v.x0, e.v.y0, e.v.step, e.cnt);
      end
      if (k == 7) begin
        compared++;
        if ({view_x0, view_y0, view_step} !== {v1.x0, v1.y0, v1.step}) begin
          mismatched++;
          $display("FAIL overflow_eighth: got %h %h %h, want view after zoom 1 %h %h %h",
                   view_x0, view_y0, view_step, v1.x0, v1.y0, v1.step);
        end
      end
    end
    compared++;
    if ({view_x0, view_y0, view_step, stack_cnt} !== {DEF_X0, DEF_Y0, DEF_STEP, 4'd0}) begin
      mismatched++;
      $display("FAIL overflow_ninth: got %h %h %h cnt %0d, want defaults cnt 0",
               view_x0, view_y0, view_step, stack_cnt);
    end
  endtask

  task automatic test_click;
    exp_t e; int ls, la, st;
    for (int k = 0; k < 3; k++) begin
      if (k == 0)      begin expect_op(0, 200, 500, 120); run_op(0, 200, 500, 120, ls, la, st); end
      else if (k == 1) begin expect_op(2, 50, 60, 70);    run_op(2, 50, 60, 70, ls, la, st); end
      else             begin expect_op(0, 300, 100, 0);   run_op(0, 300, 100, 0, ls, la, st); end
      e = sb.pop_front();
      compared++;
      if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)} ||
          ls !== e.lat || la !== e.lat + 1 || st !== 1) begin
        mismatched++;
        $display("FAIL click_%0d: got %h %h %h cnt %0d lat %0d/%0d starts %0d, want %h %h %h cnt %0d lat %0d/%0d starts 1",
                 k, view_x0, view_y0, view_step, stack_cnt, ls, la, st,
                 e.v.x0, e.v.y0, e.v.step, e.cnt, e.lat, e.lat + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e; int ls, la, st;
    engine_idle = 1'b0;
    expect_op(0, 640, 10, 200);
    fork
      begin repeat (90) @(negedge clk); engine_idle = 1'b1; end
    join_none
    run_op(0, 640, 10, 200, ls, la, st);
    e = sb.pop_front();
    compared++;
    if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)} || st !== 1 || ls <= 54) begin
      mismatched++;
      $display("FAIL engine_wait: got %h %h %h cnt %0d lat %0d starts %0d, want %h %h %h cnt %0d lat >54 starts 1",
               view_x0, view_y0, view_step, stack_cnt, ls, st, e.v.x0, e.v.y0, e.v.step, e.cnt);
    end
    expect_op(1, 0, 0, 0);
    run_op(1, 0, 0, 0, ls, la, st);
    e = sb.pop_front();
    compared++;
    if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)} || ls !== e.lat) begin
      mismatched++;
      $display("FAIL back_to_back_restore: got %h %h %h cnt %0d lat %0d, want %h %h %h cnt %0d lat %0d",
               view_x0, view_y0, view_step, stack_cnt, ls, e.v.x0, e.v.y0, e.v.step, e.cnt, e.lat);
    end
  endtask

  task automatic test_engine_busy_reset;
    exp_t e; int ls, la, st, starts, acks;
    engine_idle = 1'b0;
    @(negedge clk);
    left_pos_x = 11'd10; bot_pos_y = 11'd700; sel_length = 10'd50; mouse_zoom = 1'b1;
    @(negedge clk);
    mouse_zoom = 1'b0; interrupt = 1'b1;
    starts = 0; acks = 0;
    repeat (120) begin
      @(negedge clk);
      if (render_start === 1'b1) starts++;
      if (interrupt_ack === 1'b1) acks++;
    end
    compared++;
    if (busy !== 1'b1 || starts !== 0 || acks !== 0) begin
      mismatched++;
      $display("FAIL stall_hold: busy %b starts %0d acks %0d, want busy 1 starts 0 acks 0", busy, starts, acks);
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({view_x0, view_y0, view_step, stack_cnt, busy, render_start, interrupt_ack} !==
        {DEF_X0, DEF_Y0, DEF_STEP, 4'd0, 3'b000}) begin
      mismatched++;
      $display("FAIL midseq_reset: got %h %h %h cnt %0d busy/start/ack %b%b%b, want defaults cnt 0 000",
               view_x0, view_y0, view_step, stack_cnt, busy, render_start, interrupt_ack);
    end
    rst = 1'b0;
    engine_idle = 1'b1;
    mv = '{DEF_X0, DEF_Y0, DEF_STEP};
    mstk.delete();
    expect_op(2, 0, 0, 0);
    wait_done(ls, la, st);
    e = sb.pop_front();
    compared++;
    if ({view_x0, view_y0, view_step, stack_cnt} !== {e.v.x0, e.v.y0, e.v.step, 4'(e.cnt)} || ls !== e.lat || st !== 1) begin
      mismatched++;
      $display("FAIL reserve_after_reset: got %h %h %h cnt %0d lat %0d starts %0d, want %h %h %h cnt %0d lat %0d starts 1",
               view_x0, view_y0, view_step, stack_cnt, ls, st, e.v.x0, e.v.y0, e.v.step, e.cnt, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_first_zoom();
    test_quarter_zoom();
    test_restore();
    test_overflow();
    test_click();
    test_back_to_back();
    test_engine_busy_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
